// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - instruction memory with fixed-latency pipeline and in-order response queue
module inst_mem_responder #(
    parameter int              XLEN      = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 2,
    parameter int              QDEPTH    = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            inst_request,
    input  logic [XLEN-1:0] pc,
    output logic            req_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_inst,
    output logic            rsp_err,
    input  logic            ld_we,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [31:0]     ld_wdata
);

    localparam int              IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int              AW       = $clog2(QDEPTH);
    localparam int              PW       = AW + 1;
    localparam logic [XLEN-1:0] WORDS_X  = XLEN'(MEM_WORDS);
    localparam logic [PW-1:0]   QDEPTH_X = PW'(QDEPTH);
    localparam logic [31:0]     NOP_INST = 32'h0000_0013;

    logic [31:0] r_mem [MEM_WORDS];

    // Fetch decode: faulting fetches carry a NOP so the core never sees garbage
    logic [XLEN-1:0]  w_req_off;
    logic [XLEN-1:0]  w_req_word;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_req_ok;
    logic [31:0]      w_req_inst;
    logic             w_accept;

    assign w_req_off  = pc - BASE_ADDR;
    assign w_req_word = w_req_off >> 2;
    assign w_req_idx  = w_req_word[IDX_W-1:0];
    assign w_req_ok   = (pc[1:0] == 2'b00) && (pc >= BASE_ADDR) && (w_req_word < WORDS_X);
    assign w_req_inst = w_req_ok ? r_mem[w_req_idx] : NOP_INST;

    // Program-load decode: bad addresses are dropped, and nothing is written while in reset
    logic [XLEN-1:0]  w_ld_off;
    logic [XLEN-1:0]  w_ld_word;
    logic [IDX_W-1:0] w_ld_idx;
    logic             w_ld_en;

    assign w_ld_off  = ld_addr - BASE_ADDR;
    assign w_ld_word = w_ld_off >> 2;
    assign w_ld_idx  = w_ld_word[IDX_W-1:0];
    assign w_ld_en   = rstn && ld_we && (ld_addr[1:0] == 2'b00) &&
                       (ld_addr >= BASE_ADDR) && (w_ld_word < WORDS_X);

    // Memory array, not reset; a same-edge fetch has already sampled the old word
    always_ff @(posedge clk) begin
        if (w_ld_en) begin
            r_mem[w_ld_idx] <= ld_wdata;
        end
    end

    // Outstanding count and request handshake
    logic [PW-1:0] r_outstanding;
    logic          w_pop;

    assign req_ready = rstn && (r_outstanding < QDEPTH_X);
    assign w_accept  = inst_request && req_ready;

    // Outstanding covers both the pipeline and the queue, so the queue can never overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_pop) begin
            r_outstanding <= r_outstanding + PW'(1);
        end else if (!w_accept && w_pop) begin
            r_outstanding <= r_outstanding - PW'(1);
        end
    end

    // Latency pipeline
    logic [LATENCY-1:0] r_pv;
    logic [31:0]        r_pinst [LATENCY];
    logic [LATENCY-1:0] r_perr;

    // Pipeline valids advance every cycle; reset discards everything in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_accept;
            for (int k = 1; k < LATENCY; k++) begin
                r_pv[k] <= r_pv[k-1];
            end
        end
    end

    // Pipeline payload captured at the accept edge and shifted alongside the valids
    always_ff @(posedge clk) begin
        r_pinst[0] <= w_req_inst;
        r_perr[0]  <= !w_req_ok;
        for (int k = 1; k < LATENCY; k++) begin
            r_pinst[k] <= r_pinst[k-1];
            r_perr[k]  <= r_perr[k-1];
        end
    end

    // Response queue with an extra pointer bit to tell full from empty
    logic [31:0]     r_qinst [QDEPTH];
    logic [QDEPTH-1:0] r_qerr;
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic [AW-1:0]   w_ridx;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_ridx    = r_rptr[AW-1:0];
    assign rsp_valid = !w_empty;
    assign rsp_inst  = w_empty ? 32'h0 : r_qinst[w_ridx];
    assign rsp_err   = !w_empty && r_qerr[w_ridx];
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_pv[LATENCY-1] && (!w_full || w_pop);

    // Queue pointers wrap modulo QDEPTH through natural overflow of the low bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Queue payload write; entries stay untouched while the head is held by backpressure
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qinst[r_wptr[AW-1:0]] <= r_pinst[LATENCY-1];
            r_qerr[r_wptr[AW-1:0]]  <= r_perr[LATENCY-1];
        end
    end

endmodule
